// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial double-dabble BCD datapath.
package bcd_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] bcd_digit_t;

  // Double-dabble correction; codes 10..15 wrap mod 16 rather than flag an error.
  function automatic bcd_digit_t add3_if_ge5(input bcd_digit_t n);
    return (n >= 4'd5) ? bcd_digit_t'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bcd_nib_mux.sv
// DIGITS-to-1 nibble selector; out-of-range selects read as zero.
module bcd_nib_mux
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int SEL_W  = $clog2(DIGITS)
) (
  input  logic [NIB_W*DIGITS-1:0] q,
  input  logic [SEL_W-1:0]        sel,
  output logic [NIB_W-1:0]        nib
);

  always_comb begin
    nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sel == SEL_W'(k)) nib = q[NIB_W*k +: NIB_W];
    end
  end

endmodule

// File: rtl/bcd_dabble_reg.sv
// Cascadable BCD digit register for a serial binary-to-BCD converter:
// shift in MSB first, optional per-digit +3 correction in the same cycle.
module bcd_dabble_reg
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        adda,
  input  logic                        sin,
  input  logic [$clog2(DIGITS)-1:0]   sel,
  output logic [NIB_W*DIGITS-1:0]     q,
  output logic                        sout,
  output logic [NIB_W-1:0]            d_lo,
  output logic [NIB_W-1:0]            d_hi,
  output logic [NIB_W-1:0]            nib_o
);

  localparam int W = NIB_W * DIGITS;

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;
  logic [W-1:0] adj_q;

  // Per-digit correction; digits never carry into each other.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_q[NIB_W*gi +: NIB_W] = add3_if_ge5(q_reg[NIB_W*gi +: NIB_W]);
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    case ({en, adda})
      2'b01:   q_next = adj_q;
      2'b10:   q_next = {q_reg[W-2:0], sin};
      2'b11:   q_next = {adj_q[W-2:0], sin};
      default: q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_reg <= '0;
    else      q_reg <= q_next;
  end

  // Carry-out tracks the adjusted MSB so the next stage samples it on the same edge.
  assign sout = adda ? adj_q[W-1] : q_reg[W-1];
  assign q    = q_reg;
  assign d_lo = q_reg[NIB_W-1:0];
  assign d_hi = q_reg[2*NIB_W-1:NIB_W];

  bcd_nib_mux #(
    .DIGITS(DIGITS)
  ) u_mux (
    .q  (q_reg),
    .sel(sel),
    .nib(nib_o)
  );

endmodule

// File: tb/tb_bcd_dabble_reg.sv
// Directed bench: single 2-digit register plus a 2+3 digit chain.
module tb_bcd_dabble_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // standalone 2-digit register
  logic       en, adda, sin;
  logic [0:0] sel;
  logic [7:0] q;
  logic       sout;
  logic [3:0] d_lo, d_hi, nib;

  // chained stages: lo (2 digits) -> hi (3 digits)
  logic        c_en, c_adda, c_sin;
  logic [0:0]  lo_sel;
  logic [1:0]  hi_sel;
  logic [7:0]  lo_q;
  logic [11:0] hi_q;
  logic        lo_sout, hi_sout;
  logic [3:0]  lo_dlo, lo_dhi, lo_nib, hi_dlo, hi_dhi, hi_nib;

  bcd_dabble_reg #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .adda(adda), .sin(sin), .sel(sel),
    .q(q), .sout(sout), .d_lo(d_lo), .d_hi(d_hi), .nib_o(nib)
  );

  bcd_dabble_reg #(.DIGITS(2)) u_lo (
    .clk(clk), .rst(rst), .en(c_en), .adda(c_adda), .sin(c_sin), .sel(lo_sel),
    .q(lo_q), .sout(lo_sout), .d_lo(lo_dlo), .d_hi(lo_dhi), .nib_o(lo_nib)
  );

  bcd_dabble_reg #(.DIGITS(3)) u_hi (
    .clk(clk), .rst(rst), .en(c_en), .adda(c_adda), .sin(lo_sout), .sel(hi_sel),
    .q(hi_q), .sout(hi_sout), .d_lo(hi_dlo), .d_hi(hi_dhi), .nib_o(hi_nib)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Shift a byte into the standalone register, MSB first, no correction.
  task automatic load(input logic [7:0] v);
    en = 1'b1; adda = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sin = v[i];
      @(negedge clk);
    end
    en = 1'b0; sin = 1'b0;
  endtask

  // Asynchronous clear, applied and released between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
  endtask

  task automatic convert(input logic [7:0] b);
    en = 1'b1; adda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      sin = b[i];
      @(negedge clk);
    end
    en = 1'b0; adda = 1'b0; sin = 1'b0;
  endtask

  typedef struct {
    logic [7:0] init_q;
    logic       en;
    logic       adda;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_sout;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // init_q, en, adda, sin, exp_q, exp_sout
    vecs[0] = '{8'h58, 1'b0, 1'b1, 1'b0, 8'h8B, 1'b1};
    vecs[1] = '{8'h44, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
    vecs[3] = '{8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0};
    vecs[4] = '{8'hFA, 1'b0, 1'b1, 1'b0, 8'h2D, 1'b0};
    vecs[5] = '{8'h59, 1'b1, 1'b1, 1'b0, 8'h18, 1'b1};
    vecs[6] = '{8'hFA, 1'b1, 1'b1, 1'b1, 8'h5B, 1'b0};
    vecs[7] = '{8'h50, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b0};
    vecs[8] = '{8'h50, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
    vecs[9] = '{8'h04, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0};

    rst = 1'b0; en = 1'b0; adda = 1'b0; sin = 1'b0; sel = 1'b0;
    c_en = 1'b0; c_adda = 1'b0; c_sin = 1'b0; lo_sel = 1'b0; hi_sel = 2'd0;

    // reset state
    #3;
    chk("reset_q", q, 8'h00);
    chk("reset_sout", sout, 1'b0);
    chk("reset_hi_q", hi_q, 12'h000);
    @(negedge clk);
    rst = 1'b1;

    // async reset with no clock edge
    load(8'h5A);
    chk("pre_reset_q", q, 8'h5A);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_q", q, 8'h00);
    chk("async_reset_sout", sout, 1'b0);
    chk("async_reset_nib", nib, 4'h0);
    chk("async_reset_dlo", d_lo, 4'h0);
    chk("async_reset_dhi", d_hi, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] async reset checked");

    // table-driven single-cycle vectors
    for (int v = 0; v < 10; v++) begin
      pulse_reset();
      @(negedge clk);
      load(vecs[v].init_q);
      en = vecs[v].en; adda = vecs[v].adda; sin = vecs[v].sin;
      #1;
      chk($sformatf("vec%0d_sout", v), sout, vecs[v].exp_sout);
      @(negedge clk);
      en = 1'b0; adda = 1'b0; sin = 1'b0;
      #1;
      chk($sformatf("vec%0d_q", v), q, vecs[v].exp_q);
      chk($sformatf("vec%0d_dlo", v), d_lo, vecs[v].exp_q[3:0]);
      chk($sformatf("vec%0d_dhi", v), d_hi, vecs[v].exp_q[7:4]);
      $display("[TB] vec %0d: q 0x%02h en=%0b adda=%0b sin=%0b -> q 0x%02h sout %0b",
               v, vecs[v].init_q, vecs[v].en, vecs[v].adda, vecs[v].sin, q, sout);
    end

    // conversions from zero
    pulse_reset();
    @(negedge clk);
    convert(8'd63);
    chk("conv63_q", q, 8'h63);
    chk("conv63_dhi", d_hi, 4'h6);
    chk("conv63_dlo", d_lo, 4'h3);
    $display("[TB] convert 63 -> 0x%02h", q);

    pulse_reset();
    @(negedge clk);
    convert(8'd99);
    chk("conv99_q", q, 8'h99);
    $display("[TB] convert 99 -> 0x%02h", q);

    // nibble mux
    pulse_reset();
    @(negedge clk);
    load(8'h47);
    sel = 1'b0; #1;
    chk("mux_sel0", nib, 4'h7);
    sel = 1'b1; #1;
    chk("mux_sel1", nib, 4'h4);
    sel = 1'b0;
    $display("[TB] mux on 0x47 checked");

    // reset during the 4th cycle of a conversion of 63 (bits 0,0,1 already in)
    pulse_reset();
    @(negedge clk);
    en = 1'b1; adda = 1'b1;
    sin = 1'b0; @(negedge clk);
    sin = 1'b0; @(negedge clk);
    sin = 1'b1; @(negedge clk);
    chk("midconv_pre_q", q, 8'h01);
    sin = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("midconv_reset_q", q, 8'h00);
    chk("midconv_reset_sout", sout, 1'b0);
    en = 1'b0; adda = 1'b0; sin = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    convert(8'd99);
    chk("post_reset_conv99", q, 8'h99);
    $display("[TB] mid-conversion reset then convert 99 -> 0x%02h", q);

    // two-stage chain converting 255
    pulse_reset();
    @(negedge clk);
    c_en = 1'b1; c_adda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      c_sin = 1'(8'd255 >> i);
      @(negedge clk);
    end
    c_en = 1'b0; c_adda = 1'b0; c_sin = 1'b0;
    #1;
    chk("chain_lo_q", lo_q, 8'h55);
    chk("chain_hi_q", hi_q, 12'h002);
    chk("chain_hi_dlo", hi_dlo, 4'h2);
    hi_sel = 2'd0; #1;
    chk("chain_hi_nib0", hi_nib, 4'h2);
    hi_sel = 2'd3; #1;
    chk("chain_hi_nib_oor", hi_nib, 4'h0);
    lo_sel = 1'b1; #1;
    chk("chain_lo_nib1", lo_nib, 4'h5);
    $display("[TB] chain 255 -> hi 0x%03h lo 0x%02h", hi_q, lo_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
